dsp_mac_sequencer: RTL and testbench

Upstream control stage for the DSP48A1 slice. It accepts a dot-product command of N operand pairs, streams the pairs into the slice's A/B ports and generates the matching per-cycle OPMODE so the post-adder accumulates (or subtracts) the products. It then waits out the slice pipeline and returns the final P value through a valid/ready result port. One command is in flight at a time.

---
 rtl/dsp_seq_pkg.sv | 18 +
 rtl/opm_delay.sv | 33 +++
 rtl/dsp_mac_sequencer.sv | 139 +++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_seq_pkg.sv
// Shared types and OPMODE encodings for the DSP48A1 MAC sequencer.
package dsp_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    // OPMODE fields: [1:0] X mux, [3:2] Z mux, [7] post-adder subtract.
    localparam logic [7:0] OPM_ZERO    = 8'h00;
    localparam logic [7:0] OPM_HOLD    = 8'h08;
    localparam logic [7:0] OPM_FIRST   = 8'h01;
    localparam logic [7:0] OPM_ACC     = 8'h09;
    localparam int         OPM_SUB_BIT = 7;

endpackage

// File: rtl/opm_delay.sv
// OPMODE delay line that lines each slot up with its product at the post-adder.
module opm_delay
    import dsp_seq_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_pipe
            logic [7:0] stage [DEPTH];

            // NOTE: every stage is reset so a stale slot can never reach the slice after reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= OPM_ZERO;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Streams dot-product operand pairs into a DSP48A1 slice, drives its OPMODE,
// and returns the accumulated P value over a valid/ready result port.
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int LEN_W   = 10,
    parameter int OPM_DLY = 1,
    parameter int P_LAT   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_sub,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    input  logic [47:0]      dsp_p,
    input  logic             dsp_carryout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic             res_carry,
    output logic             busy
);

    localparam int              CNT_W    = (P_LAT > 1) ? $clog2(P_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_LAT - 1);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] remaining;
    logic             sub_q;
    logic             first_q;
    logic             acc_pending;  // a real accumulation owns P until its result is taken
    logic [CNT_W-1:0] drain_cnt;
    logic             cmd_hs, in_hs, res_hs, drain_last;
    logic [7:0]       opm_slot;

    assign cmd_ready  = (state == S_IDLE) && !rst;
    assign in_ready   = (state == S_STREAM) && !rst;
    assign res_valid  = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    assign cmd_hs     = cmd_valid && cmd_ready;
    assign in_hs      = in_valid && in_ready;
    assign res_hs     = res_valid && res_ready;
    assign drain_last = (state == S_DRAIN) && (drain_cnt == CNT_LAST);
    assign dsp_a      = in_a;
    assign dsp_b      = in_b;

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_nxt = state;
        opm_slot  = acc_pending ? OPM_HOLD : OPM_ZERO;
        unique case (state)
            S_IDLE: begin
                if (cmd_hs) state_nxt = (cmd_len == '0) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                opm_slot = OPM_HOLD;
                if (in_hs) begin
                    opm_slot              = first_q ? OPM_FIRST : OPM_ACC;
                    opm_slot[OPM_SUB_BIT] = sub_q;
                    if (remaining == LEN_W'(1)) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_last) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (res_hs) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            remaining   <= '0;
            sub_q       <= 1'b0;
            first_q     <= 1'b0;
            acc_pending <= 1'b0;
            drain_cnt   <= '0;
            res_data    <= '0;
            res_carry   <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE: begin
                    if (cmd_hs) begin
                        remaining   <= cmd_len;
                        sub_q       <= cmd_sub;
                        first_q     <= 1'b1;
                        acc_pending <= (cmd_len != '0);
                        drain_cnt   <= '0;
                        if (cmd_len == '0) begin
                            res_data  <= '0;
                            res_carry <= 1'b0;
                        end
                    end
                end
                S_STREAM: begin
                    if (in_hs) begin
                        remaining <= remaining - LEN_W'(1);
                        first_q   <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + CNT_W'(1);
                    // P only reflects the last product once the slice pipeline has drained.
                    if (drain_last) begin
                        res_data  <= dsp_p;
                        res_carry <= dsp_carryout;
                    end
                end
                S_DONE: begin
                    if (res_hs) acc_pending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    opm_delay #(
        .DEPTH (OPM_DLY)
    ) u_opm_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (opm_slot),
        .dout (dsp_opmode)
    );

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a small DSP48A1 slice model
// (A1/B1 -> M -> P registers, registered OPMODE) closing the loop.
module tb_dsp_mac_sequencer;
    import dsp_seq_pkg::*;

    localparam int LEN_W = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready, cmd_sub;
    logic [LEN_W-1:0] cmd_len;
    logic             in_valid, in_ready;
    logic [17:0]      in_a, in_b, dsp_a, dsp_b;
    logic [7:0]       dsp_opmode;
    logic [47:0]      dsp_p;
    logic             dsp_carryout;
    logic             res_valid, res_ready, res_carry, busy;
    logic [47:0]      res_data;

    int checks = 0;
    int errors = 0;

    logic [17:0] pa [4];
    logic [17:0] pb [4];

    always #5 clk = ~clk;

    dsp_mac_sequencer #(
        .LEN_W   (LEN_W),
        .OPM_DLY (1),
        .P_LAT   (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_len      (cmd_len),
        .cmd_sub      (cmd_sub),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .dsp_a        (dsp_a),
        .dsp_b        (dsp_b),
        .dsp_opmode   (dsp_opmode),
        .dsp_p        (dsp_p),
        .dsp_carryout (dsp_carryout),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_carry    (res_carry),
        .busy         (busy)
    );

    // Slice model: A1REG=B1REG=1, MREG=1, OPMODEREG=1, PREG=1.
    logic [17:0] a1_r, b1_r;
    logic [35:0] m_r;
    logic [7:0]  opm_r;
    logic [47:0] p_r;
    logic        carry_r;
    logic [48:0] x_v, z_v, sum_v;

    always_comb begin
        x_v   = (opm_r[1:0] == 2'b01) ? {13'b0, m_r} : 49'd0;
        z_v   = (opm_r[3:2] == 2'b10) ? {1'b0, p_r} : 49'd0;
        sum_v = opm_r[7] ? (z_v - x_v) : (z_v + x_v);
    end

    always @(posedge clk) begin
        if (rst) begin
            a1_r <= '0; b1_r <= '0; m_r <= '0; opm_r <= '0; p_r <= '0; carry_r <= 1'b0;
        end else begin
            a1_r    <= dsp_a;
            b1_r    <= dsp_b;
            m_r     <= a1_r * b1_r;
            opm_r   <= dsp_opmode;
            p_r     <= sum_v[47:0];
            carry_r <= sum_v[48];
        end
    end

    assign dsp_p        = p_r;
    assign dsp_carryout = carry_r;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [47:0] observed, input logic [47:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Accepts one command, streams pa/pb (optionally with a bubble on every
    // second stream cycle), checks each OPMODE slot one cycle later, then
    // waits for res_valid. lat is measured from the command-accept cycle.
    task automatic do_dot(input int n, input bit sub, input bit bubbles, output int lat);
        int          cyc;
        int          idx;
        int          guard;
        logic [7:0]  exp_slot;
        logic [7:0]  prev_slot;
        bit          have_prev;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(n);
        cmd_sub   = sub;
        guard     = 0;
        while (!cmd_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("cmd_ready_wait", {47'd0, cmd_ready}, 48'd1);
        tick();
        cmd_valid = 1'b0;
        cyc       = 1;
        idx       = 0;
        have_prev = 1'b0;
        prev_slot = OPM_ZERO;
        while (idx < n && cyc < 200) begin
            if (have_prev) check("opm_stream_slot", {40'd0, dsp_opmode}, {40'd0, prev_slot});
            check("in_ready_stream", {47'd0, in_ready}, 48'd1);
            if (bubbles && cyc[0] == 1'b0) begin
                in_valid = 1'b0;
                exp_slot = OPM_HOLD;
            end else begin
                in_valid = 1'b1;
                in_a     = pa[idx];
                in_b     = pb[idx];
                exp_slot = (idx == 0) ? 8'h01 : 8'h09;
                if (sub) exp_slot[7] = 1'b1;
                idx++;
            end
            prev_slot = exp_slot;
            have_prev = 1'b1;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("opm_last_slot", {40'd0, dsp_opmode}, {40'd0, prev_slot});
        while (!res_valid && cyc < 200) begin
            tick();
            cyc++;
            check("opm_drain_hold", {40'd0, dsp_opmode}, 48'h08);
        end
        lat = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_sub   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_cmd_ready", {47'd0, cmd_ready}, 48'd0);
        check("rst_in_ready", {47'd0, in_ready}, 48'd0);
        rst = 1'b0;
        #1;
        check("post_rst_cmd_ready", {47'd0, cmd_ready}, 48'd1);
        check("post_rst_busy", {47'd0, busy}, 48'd0);
        check("post_rst_res_valid", {47'd0, res_valid}, 48'd0);
        check("post_rst_res_data", res_data, 48'd0);
        check("post_rst_res_carry", {47'd0, res_carry}, 48'd0);
        check("post_rst_opmode", {40'd0, dsp_opmode}, 48'd0);

        // Accumulate: 1*2 + 2*2 + 3*2 + 4*2 = 20
        pa = '{18'd1, 18'd2, 18'd3, 18'd4};
        pb = '{18'd2, 18'd2, 18'd2, 18'd2};
        do_dot(4, 1'b0, 1'b0, lat);
        check("acc_latency", 48'(lat), 48'd8);
        check("acc_res_valid", {47'd0, res_valid}, 48'd1);
        check("acc_res_data", res_data, 48'd20);
        check("acc_res_carry", {47'd0, res_carry}, 48'd0);
        check("acc_busy", {47'd0, busy}, 48'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("acc_idle_cmd_ready", {47'd0, cmd_ready}, 48'd1);
        check("acc_idle_busy", {47'd0, busy}, 48'd0);

        // Subtract: 0 - (3*5 + 2*2) = -19
        pa = '{18'd3, 18'd2, 18'd0, 18'd0};
        pb = '{18'd5, 18'd2, 18'd0, 18'd0};
        do_dot(2, 1'b1, 1'b0, lat);
        check("sub_latency", 48'(lat), 48'd6);
        check("sub_res_data", res_data, 48'hFFFF_FFFF_FFED);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Bubbles on alternating cycles: handshakes at 1,3,5,7 -> res_valid at 11
        pa = '{18'd1, 18'd2, 18'd3, 18'd4};
        pb = '{18'd2, 18'd2, 18'd2, 18'd2};
        do_dot(4, 1'b0, 1'b1, lat);
        check("bub_latency", 48'(lat), 48'd11);
        check("bub_res_data", res_data, 48'd20);

        // Backpressure on the pending result, with a command offered throughout
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(3);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_res_data", res_data, 48'd20);
            check("bp_res_valid", {47'd0, res_valid}, 48'd1);
            check("bp_cmd_ready", {47'd0, cmd_ready}, 48'd0);
            check("bp_busy", {47'd0, busy}, 48'd1);
        end
        res_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        check("bp_idle_busy", {47'd0, busy}, 48'd0);
        check("bp_idle_cmd_ready", {47'd0, cmd_ready}, 48'd1);
        check("bp_idle_res_valid", {47'd0, res_valid}, 48'd0);

        // Zero-length command
        cmd_valid = 1'b1;
        cmd_len   = '0;
        cmd_sub   = 1'b0;
        tick();
        cmd_valid = 1'b0;
        check("zero_res_valid", {47'd0, res_valid}, 48'd1);
        check("zero_res_data", res_data, 48'd0);
        check("zero_res_carry", {47'd0, res_carry}, 48'd0);
        check("zero_opmode_a", {40'd0, dsp_opmode}, 48'd0);
        tick();
        check("zero_opmode_b", {40'd0, dsp_opmode}, 48'd0);
        check("zero_res_valid_held", {47'd0, res_valid}, 48'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("zero_idle_cmd_ready", {47'd0, cmd_ready}, 48'd1);
        check("zero_idle_opmode", {40'd0, dsp_opmode}, 48'd0);

        // Reset pulsed on the 2nd pair of a length-4 command
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(4);
        tick();
        cmd_valid = 1'b0;
        in_valid  = 1'b1;
        in_a      = 18'd1;
        in_b      = 18'd2;
        tick();
        in_a = 18'd2;
        rst  = 1'b1;
        #1;
        check("rstmid_in_ready", {47'd0, in_ready}, 48'd0);
        check("rstmid_cmd_ready", {47'd0, cmd_ready}, 48'd0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rstmid_after_cmd_ready", {47'd0, cmd_ready}, 48'd1);
        check("rstmid_after_res_valid", {47'd0, res_valid}, 48'd0);
        check("rstmid_after_busy", {47'd0, busy}, 48'd0);
        check("rstmid_after_opmode", {40'd0, dsp_opmode}, 48'd0);
        tick();
        tick();
        check("rstmid_idle_opmode", {40'd0, dsp_opmode}, 48'd0);
        check("rstmid_idle_res_valid", {47'd0, res_valid}, 48'd0);

        pa = '{18'd1, 18'd2, 18'd3, 18'd4};
        pb = '{18'd2, 18'd2, 18'd2, 18'd2};
        do_dot(4, 1'b0, 1'b0, lat);
        check("rstmid_next_latency", 48'(lat), 48'd8);
        check("rstmid_next_res_data", res_data, 48'd20);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("final_cmd_ready", {47'd0, cmd_ready}, 48'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
